// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler
//
// Drives the I2S transmitter's timing and supplies one mixed sample per frame.
// A clock divider produces the bit-clock enable, a 5-bit counter tracks the
// position inside the 32-bit frame, and once per frame a small FSM polls up to
// NUM_VOICES voices over req/ack, accumulates their samples, shifts and
// saturates the sum, and stages it for the next frame boundary.
//
// Ports:
//   clk            system clock (24.576 MHz)
//   rst            asynchronous active-low reset
//   voice_enable   per-voice mix enable, latched at frame start
//   voice_ack      per-voice data-valid acknowledge
//   voice_data     16-bit signed sample per voice, voice i at [16i+15:16i]
//   master_shift   arithmetic right shift of the sum, latched at frame start
//   voice_req      one-hot request to the voice currently polled
//   bit_clk_en     one-cycle enable for the transmitter bit clock
//   frame_start    one-cycle pulse on the bit_clk_en where bit_pos is 31
//   sample_out     mixed sample, stable for a whole frame
//   timeout_flags  sticky per-voice ack-timeout flags
//   late_mix       pulse when a frame starts before the mix has finished
module i2s_frame_scheduler #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_VOICES-1:0]      voice_enable,
   input  logic [NUM_VOICES-1:0]      voice_ack,
   input  logic [16*NUM_VOICES-1:0]   voice_data,
   input  logic [1:0]                 master_shift,
   output logic [NUM_VOICES-1:0]      voice_req,
   output logic                       bit_clk_en,
   output logic                       frame_start,
   output logic [15:0]                sample_out,
   output logic [NUM_VOICES-1:0]      timeout_flags,
   output logic                       late_mix
);

   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam int unsigned IdxW = $clog2(NUM_VOICES + 1);
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StSat, StDone} state_e;

   state_e                   state_q, state_d;
   logic [DivW-1:0]          div_q;
   logic [4:0]               bit_pos_q;
   logic [IdxW-1:0]          idx_q;
   logic [TmoW-1:0]          tmo_q;
   logic signed [18:0]       acc_q;
   logic [NUM_VOICES-1:0]    en_q;
   logic [1:0]               shift_q;
   logic [15:0]              mix_q;

   logic [NUM_VOICES-1:0]    sel_onehot;
   logic                     sel_en;
   logic                     sel_ack;
   logic [15:0]              sel_data;
   logic                     idx_end;
   logic                     tmo_last;
   logic signed [18:0]       shifted;
   logic [15:0]              sat;

   // ---------------------------------------------------------------- timing
   assign bit_clk_en  = (div_q == DivW'(CLK_DIV - 1));
   assign frame_start = bit_clk_en && (bit_pos_q == 5'd31);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         bit_pos_q <= 5'd31;
      end else begin
         div_q <= bit_clk_en ? '0 : div_q + DivW'(1);
         if (bit_clk_en) begin
            bit_pos_q <= bit_pos_q + 5'd1;
         end
      end
   end

   // ------------------------------------------------------- voice selection
   // idx_q may equal NUM_VOICES (end of poll), in which case nothing matches.
   always_comb begin
      sel_onehot = '0;
      sel_en     = 1'b0;
      sel_ack    = 1'b0;
      sel_data   = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         if (idx_q == IdxW'(i)) begin
            sel_onehot[i] = 1'b1;
            sel_en        = en_q[i];
            sel_ack       = voice_ack[i];
            sel_data      = voice_data[16*i +: 16];
         end
      end
   end

   assign idx_end  = (idx_q == IdxW'(NUM_VOICES));
   assign tmo_last = (tmo_q == TmoW'(TIMEOUT - 1));

   // Accumulator has 3 guard bits, enough for 8 full-scale voices.
   assign shifted = acc_q >>> shift_q;

   always_comb begin
      if (shifted > 19'sd32767) begin
         sat = 16'h7fff;
      end else if (shifted < -19'sd32768) begin
         sat = 16'h8000;
      end else begin
         sat = shifted[15:0];
      end
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A frame boundary always restarts the poll, finished or not.
   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = StReq;
      end else begin
         case (state_q)
            StReq: begin
               if (idx_end) begin
                  state_d = StSat;
               end else if (sel_en) begin
                  state_d = StWait;
               end
            end
            StWait: begin
               if (sel_ack || tmo_last) begin
                  state_d = StReq;
               end
            end
            StSat:   state_d = StDone;
            default: state_d = state_q;
         endcase
      end
   end

   // Requests derive from state, so an async reset drops them at once.
   always_comb begin
      voice_req = (state_q == StWait) ? sel_onehot : '0;
      late_mix  = frame_start &&
                  ((state_q == StReq) || (state_q == StWait) || (state_q == StSat));
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q         <= '0;
         tmo_q         <= '0;
         acc_q         <= '0;
         en_q          <= '0;
         shift_q       <= '0;
         mix_q         <= '0;
         sample_out    <= '0;
         timeout_flags <= '0;
      end else if (frame_start) begin
         // The transmitter captures the old sample_out on this same edge.
         sample_out <= mix_q;
         acc_q      <= '0;
         idx_q      <= '0;
         en_q       <= voice_enable;
         shift_q    <= master_shift;
      end else begin
         case (state_q)
            StReq: begin
               if (!idx_end) begin
                  if (sel_en) begin
                     tmo_q <= '0;
                  end else begin
                     idx_q <= idx_q + IdxW'(1);
                  end
               end
            end
            StWait: begin
               if (sel_ack) begin
                  acc_q <= acc_q + {{3{sel_data[15]}}, sel_data};
                  idx_q <= idx_q + IdxW'(1);
               end else if (tmo_last) begin
                  timeout_flags <= timeout_flags | sel_onehot;
                  idx_q         <= idx_q + IdxW'(1);
               end else begin
                  tmo_q <= tmo_q + TmoW'(1);
               end
            end
            StSat:   mix_q <= sat;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Bench for i2s_frame_scheduler: two instances share clock and reset, one
// with the default TIMEOUT and one with a long TIMEOUT so that slow voices
// overrun the frame. Voices are emulated by a per-voice ack-delay responder.
module tb_i2s_frame_scheduler;

   localparam int NV     = 4;
   localparam int PERIOD = 512;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NV-1:0]    en    [2];
   logic [1:0]       shf   [2];
   logic [NV-1:0]    ack   [2];
   logic [16*NV-1:0] vdata [2];
   logic [NV-1:0]    req   [2];
   logic             bce   [2];
   logic             fs    [2];
   logic [15:0]      sout  [2];
   logic [NV-1:0]    tflags[2];
   logic             late  [2];

   int dly    [2][NV];
   int hi_cnt [2][NV];

   int vectors     = 0;
   int miscompares = 0;
   int prev_mix   [2];
   logic [NV-1:0] flag_model [2];

   i2s_frame_scheduler #(.CLK_DIV(16), .NUM_VOICES(NV), .TIMEOUT(64)) u_dut (
      .clk(clk), .rst(rst), .voice_enable(en[0]), .voice_ack(ack[0]),
      .voice_data(vdata[0]), .master_shift(shf[0]), .voice_req(req[0]),
      .bit_clk_en(bce[0]), .frame_start(fs[0]), .sample_out(sout[0]),
      .timeout_flags(tflags[0]), .late_mix(late[0])
   );

   i2s_frame_scheduler #(.CLK_DIV(16), .NUM_VOICES(NV), .TIMEOUT(256)) u_dut_slow (
      .clk(clk), .rst(rst), .voice_enable(en[1]), .voice_ack(ack[1]),
      .voice_data(vdata[1]), .master_shift(shf[1]), .voice_req(req[1]),
      .bit_clk_en(bce[1]), .frame_start(fs[1]), .sample_out(sout[1]),
      .timeout_flags(tflags[1]), .late_mix(late[1])
   );

   // Voice i acks once its request has been seen high for dly cycles.
   always @(posedge clk) begin
      #1;
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < NV; i++) begin
            if (req[u][i] === 1'b1) begin
               hi_cnt[u][i] = hi_cnt[u][i] + 1;
               ack[u][i]    = (hi_cnt[u][i] >= dly[u][i]);
            end else begin
               hi_cnt[u][i] = 0;
               ack[u][i]    = 1'b0;
            end
         end
      end
   end

   function automatic int tmo_of(input int u);
      return (u == 0) ? 64 : 256;
   endfunction

   function automatic logic [16*NV-1:0] pack4(input int a, input int b, input int c,
                                               input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Reference: expected mix, cycles from frame edge to mix commit, timeouts,
   // and how many cycles each voice's request should stay high.
   function automatic void model_frame(input int u, output int mix, output int dur,
                                       output logic [NV-1:0] tset, output int rlen [NV]);
      int sum;
      int w;
      int div;
      logic signed [15:0] s16;
      logic [16*NV-1:0] d;
      sum  = 0;
      dur  = 2;
      tset = '0;
      d    = vdata[u];
      for (int i = 0; i < NV; i++) begin
         rlen[i] = 0;
         if (!en[u][i]) begin
            dur += 1;
         end else begin
            w = (dly[u][i] < 1) ? 1 : dly[u][i];
            if (w <= tmo_of(u)) begin
               s16 = d[16*i +: 16];
               sum += int'(s16);
            end else begin
               w       = tmo_of(u);
               tset[i] = 1'b1;
            end
            rlen[i] = w;
            dur += 1 + w;
         end
      end
      div = 1 << shf[u];
      if (sum >= 0) sum = sum / div;
      else          sum = -((-sum + div - 1) / div);
      if (sum > 32767)       mix = 32767;
      else if (sum < -32768) mix = -32768;
      else                   mix = sum;
   endfunction

   // Configure one frame at a frame_start, run it, and check it at the next.
   task automatic do_frame(input int u, input logic [NV-1:0] e, input logic [1:0] s,
                           input logic [16*NV-1:0] d, input int d0, input int d1,
                           input int d2, input int d3, input bit scramble);
      int cnt;
      int mix;
      int dur;
      logic [NV-1:0] tset;
      int rlen [NV];
      int rq [NV];
      logic overlap;
      logic stray;
      logic exp_late;
      cnt = 0;
      while (fs[u] !== 1'b1 && cnt < 600) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (fs[u] !== 1'b1) begin
         miscompares++;
         $display("FAIL frame_sync u%0d: frame_start=%b after %0d cycles, required 1", u,
                  fs[u], cnt);
      end
      en[u] = e;  shf[u] = s;  vdata[u] = d;
      dly[u][0] = d0;  dly[u][1] = d1;  dly[u][2] = d2;  dly[u][3] = d3;
      model_frame(u, mix, dur, tset, rlen);
      exp_late = (dur >= PERIOD);
      @(negedge clk);
      vectors++;
      if (sout[u] !== 16'(prev_mix[u])) begin
         miscompares++;
         $display("FAIL sample_out u%0d: got %0d required %0d", u, $signed(sout[u]),
                  prev_mix[u]);
      end
      // Mid-frame changes must be ignored until the next frame start.
      if (scramble) begin
         en[u]  = ~e;
         shf[u] = ~s;
      end
      for (int i = 0; i < NV; i++) rq[i] = 0;
      overlap = 1'b0;
      stray   = 1'b0;
      cnt     = 1;
      while (1) begin
         if (!$onehot0(req[u])) overlap = 1'b1;
         if (late[u] === 1'b1 && fs[u] !== 1'b1) stray = 1'b1;
         for (int i = 0; i < NV; i++) if (req[u][i] === 1'b1) rq[i]++;
         if (fs[u] === 1'b1 || cnt >= 600) break;
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (cnt != PERIOD) begin
         miscompares++;
         $display("FAIL frame_period u%0d: got %0d cycles required %0d", u, cnt, PERIOD);
      end
      vectors++;
      if (late[u] !== exp_late) begin
         miscompares++;
         $display("FAIL late_mix u%0d: got %b required %b (mix takes %0d cycles)", u,
                  late[u], exp_late, dur);
      end
      vectors++;
      if ({overlap, stray} !== 2'b00) begin
         miscompares++;
         $display("FAIL req_onehot/stray_late u%0d: got overlap=%b stray=%b required 0 0",
                  u, overlap, stray);
      end
      if (!exp_late) begin
         for (int i = 0; i < NV; i++) begin
            vectors++;
            if (rq[i] != rlen[i]) begin
               miscompares++;
               $display("FAIL req_len u%0d voice%0d: high %0d cycles required %0d", u, i,
                        rq[i], rlen[i]);
            end
         end
         prev_mix[u]   = mix;
         flag_model[u] = flag_model[u] | tset;
         vectors++;
         if (tflags[u] !== flag_model[u]) begin
            miscompares++;
            $display("FAIL timeout_flags u%0d: got %b required %b", u, tflags[u],
                     flag_model[u]);
         end
      end
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         en[u] = '0;  shf[u] = '0;  vdata[u] = '0;
         prev_mix[u] = 0;  flag_model[u] = '0;
         for (int i = 0; i < NV; i++) dly[u][i] = 1;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         vectors++;
         if ({req[u], bce[u], fs[u], sout[u], tflags[u], late[u]} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs u%0d: req=%b bce=%b fs=%b sout=%h flags=%b late=%b required all 0",
                     u, req[u], bce[u], fs[u], sout[u], tflags[u], late[u]);
         end
      end
      rst = 1'b1;
      for (int k = 0; k < 48; k++) begin
         for (int u = 0; u < 2; u++) begin
            vectors++;
            if ({bce[u], fs[u]} !== {(k % 16) == 15, k == 15}) begin
               miscompares++;
               $display("FAIL divider u%0d cycle %0d: bce=%b fs=%b required %b %b", u, k,
                        bce[u], fs[u], (k % 16) == 15, k == 15);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mix_basic();
      do_frame(0, 4'hF, 2'd0, pack4(1000, 2000, -500, 300), 1, 1, 1, 1, 1'b0);
      do_frame(0, 4'hF, 2'd0, pack4(1000, 2000, -500, 300), 1, 1, 1, 1, 1'b0);
   endtask

   task automatic test_saturation();
      do_frame(0, 4'hF, 2'd0, pack4(30000, 30000, 30000, 30000), 1, 2, 3, 1, 1'b0);
      do_frame(0, 4'hF, 2'd0, pack4(-30000, -30000, -30000, -30000), 2, 1, 1, 3, 1'b0);
      do_frame(0, 4'hF, 2'd2, pack4(30000, 30000, 30000, 30000), 1, 1, 1, 1, 1'b0);
   endtask

   task automatic test_enable_mask();
      do_frame(0, 4'b0101, 2'd0, pack4(1234, 5000, -4321, 7000), 3, 1, 5, 1, 1'b1);
   endtask

   task automatic test_timeout();
      do_frame(0, 4'hF, 2'd0, pack4(100, 9999, 200, 300), 1, 1000, 2, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 7; n++) begin
         do_frame(0, 4'($urandom), 2'($urandom), {$urandom, $urandom},
                  $urandom_range(1, 80), $urandom_range(1, 80), $urandom_range(1, 80),
                  $urandom_range(1, 80), 1'($urandom));
      end
   endtask

   task automatic test_late();
      do_frame(1, 4'hF, 2'd0, pack4(1111, 2222, 3333, 4444), 200, 200, 200, 200, 1'b0);
      do_frame(1, 4'hF, 2'd0, pack4(1111, 2222, 3333, 4444), 200, 200, 200, 200, 1'b0);
      // Commit lands one cycle before the boundary, then exactly on it.
      do_frame(1, 4'hF, 2'd0, pack4(100, 200, 300, 400), 126, 126, 126, 127, 1'b0);
      do_frame(1, 4'hF, 2'd0, pack4(5, 6, 7, 8), 126, 126, 127, 127, 1'b0);
      for (int n = 0; n < 5; n++) begin
         do_frame(1, 4'hF, 2'($urandom), {$urandom, $urandom},
                  $urandom_range(115, 140), $urandom_range(115, 140),
                  $urandom_range(115, 140), $urandom_range(115, 140), 1'b0);
      end
   endtask

   task automatic test_async_reset();
      int cnt;
      dly[1][0] = 200;
      cnt = 0;
      while (req[1] === '0 && cnt < 600) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (req[1] === '0) begin
         miscompares++;
         $display("FAIL reset_setup: voice_req never asserted, got %b", req[1]);
      end
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({req[0], req[1], sout[1], tflags[0], late[1]} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: req0=%b req1=%b sout1=%h flags0=%b late1=%b required all 0",
                  req[0], req[1], sout[1], tflags[0], late[1]);
      end
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (req[0] !== '0 || req[1] !== '0) cnt++;
      end
      vectors++;
      if (cnt != 0) begin
         miscompares++;
         $display("FAIL idle_after_reset: requests seen on %0d cycles, required 0", cnt);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mix_basic();
      test_saturation();
      test_enable_mask();
      test_timeout();
      test_random();
      test_late();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
